oflow_bbox_feeder: RTL and testbench
====================================

# oflow_bbox_feeder

Frame-level bounding-box source for `oflow_features_extraction`. It collects the detected objects of one frame from the detection front-end through a valid/ready write port and stores them in an internal buffer. It then replays them one per cycle on the `bbox`/`fe_enable` interface, the input side of feature extraction, with a downstream stall input and an end-of-frame pulse.

## Interface

Parameters:
- `CM_LEN`, 11, width of each centre-of-mass coordinate (x, y)
- `WIDTH_LEN`, 10, bbox width field
- `HEIGHT_LEN`, 10, bbox height field
- `COLOR_LEN`, 24, each colour field
- `D_HISTORY_LEN`, 3, d_history field
- `DEPTH`, 16, buffer entries; power of two, ≥2
- `BBOX_VECTOR_SIZE`, 2*CM_LEN+WIDTH_LEN+HEIGHT_LEN+2*COLOR_LEN+D_HISTORY_LEN (93), derived; do not override
- `CNT_W`, $clog2(DEPTH+1) (5), derived

Ports:
- `clk` in 1 — single clock; all logic on rising edge
- `reset_N` in 1 — asynchronous, active-low reset
- `in_valid` in 1 — object fields valid
- `in_ready` out 1 — buffer accepts object; transfer when `in_valid && in_ready`
- `in_x`, `in_y` in CM_LEN — centre of mass
- `in_width` in WIDTH_LEN, `in_height` in HEIGHT_LEN
- `in_color1`, `in_color2` in COLOR_LEN
- `in_d_history` in D_HISTORY_LEN
- `frame_end` in 1 — single-cycle pulse closing the current frame; independent of `in_valid`
- `fe_stall` in 1 — downstream cannot take a bbox this cycle
- `bbox` out BBOX_VECTOR_SIZE — {x,y,width,height,color1,color2,d_history}, x in MSBs
- `fe_enable` out 1 — `bbox` valid this cycle
- `frame_done` out 1 — one-cycle pulse after last bbox of a frame
- `obj_count` out CNT_W — objects in current/last frame; valid with `frame_done`
- `busy` out 1 — state ≠ LOAD

## Operation

- FSM states: LOAD, SEND, DONE. Reset state LOAD.
- LOAD: `in_ready = (cnt < DEPTH)`. Each accepted object is packed and written to `mem[cnt]`, and `cnt` increments. When the buffer is full, `in_ready` is low (backpressure, nothing dropped). `frame_end` moves the FSM to SEND. If `frame_end` and an accepted object occur in the same cycle, the object belongs to the closing frame. `frame_end` while full is legal.
- SEND: `in_ready = 0`, and `frame_end` is ignored (the upstream must not pulse it). At each edge:
  - If `rd == cnt`: `fe_enable <= 0` and go to DONE.
  - Else if `!fe_stall`: `bbox <= mem[rd]`, `fe_enable <= 1`, `rd++`.
  - Else: `fe_enable <= 0` and `bbox` holds.
- DONE: `frame_done = 1` for exactly one cycle, with `obj_count = cnt`. Next edge: `cnt <= 0`, `rd <= 0`, go to LOAD.
- `obj_count` always tracks `cnt`.
- Zero-object frame (`frame_end` with `cnt == 0`): SEND lasts one cycle with no `fe_enable`, then DONE with `obj_count = 0`.
- Buffer contents are not reset; only `cnt`, `rd`, state and outputs reset.
- Reset mid-frame: everything returns to reset values immediately; the partial frame is discarded.

## Timing

- Reset values: `in_ready = 1`, `bbox = 0`, `fe_enable = 0`, `frame_done = 0`, `obj_count = 0`, `busy = 0`.
- `bbox`, `fe_enable` are registered. `frame_done`, `busy`, `in_ready` decode from registered state/counters.
- With `frame_end` at cycle f and no stalls:
  - SEND occupies cycle f+1.
  - bbox[i] is visible at cycle f+2+i.
  - DONE occupies cycle f+2+N.
  - LOAD with `in_ready` resumes at cycle f+3+N.
- Each stalled cycle in SEND adds exactly one cycle. `fe_stall` is sampled only in SEND.
- Throughput is one bbox per cycle. `fe_enable` is never high outside the N valid cycles.

## Test plan

- Two objects (x=50,y=10,w=10,h=100,c1=50,c2=60,dh=6) then (30,70,10,100,50,60,6), then `frame_end` at cycle f. Required:
  - `fe_enable` high at f+2 and f+3, with `bbox` equal to the packed vectors in order.
  - `frame_done` at f+4 with `obj_count = 2`.
  - `in_ready` high at f+5.
- Write 17 objects with `in_valid` held high. Required: `in_ready` drops after the 16th acceptance, and the 17th waits. Then `frame_end`: 16 bboxes replay, `obj_count = 16`. The 17th is accepted in the next LOAD.
- `frame_end` with no objects. Required: no `fe_enable`, and `frame_done` with `obj_count = 0` at f+2.
- Three-object frame with `fe_stall` high during the cycle that would issue object 1. Required:
  - `fe_enable` pattern 1,0,1,1.
  - Order preserved.
  - `frame_done` one cycle later than the unstalled case.
- `frame_end` coincident with the accepted 3rd object. Required: that object is replayed, and `obj_count = 3`.
- Assert `reset_N = 0` mid-SEND. Required: `fe_enable` and `busy` drop immediately, `in_ready = 1`, and the next frame starts at index 0.

Source files
------------

// File: rtl/oflow_bbox_feeder.sv
// oflow_bbox_feeder: buffers one frame of detected objects from a valid/ready
// write port, then replays them one per cycle as packed bbox vectors to
// feature extraction, honouring a downstream stall and closing with a pulse.
module oflow_bbox_feeder #(
    parameter int unsigned CM_LEN           = 11,
    parameter int unsigned WIDTH_LEN        = 10,
    parameter int unsigned HEIGHT_LEN       = 10,
    parameter int unsigned COLOR_LEN        = 24,
    parameter int unsigned D_HISTORY_LEN    = 3,
    parameter int unsigned DEPTH            = 16,
    parameter int unsigned BBOX_VECTOR_SIZE = 2*CM_LEN + WIDTH_LEN + HEIGHT_LEN
                                              + 2*COLOR_LEN + D_HISTORY_LEN,
    parameter int unsigned CNT_W            = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        reset_N,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CM_LEN-1:0]           in_x,
    input  logic [CM_LEN-1:0]           in_y,
    input  logic [WIDTH_LEN-1:0]        in_width,
    input  logic [HEIGHT_LEN-1:0]       in_height,
    input  logic [COLOR_LEN-1:0]        in_color1,
    input  logic [COLOR_LEN-1:0]        in_color2,
    input  logic [D_HISTORY_LEN-1:0]    in_d_history,
    input  logic                        frame_end,
    input  logic                        fe_stall,
    output logic [BBOX_VECTOR_SIZE-1:0] bbox,
    output logic                        fe_enable,
    output logic                        frame_done,
    output logic [CNT_W-1:0]            obj_count,
    output logic                        busy
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                      r_state;
    logic [CNT_W-1:0]            r_cnt;
    logic [CNT_W-1:0]            r_rd;
    logic [BBOX_VECTOR_SIZE-1:0] r_bbox;
    logic                        r_fe_enable;
    logic [BBOX_VECTOR_SIZE-1:0] r_mem [DEPTH];

    logic                        w_full;
    logic                        w_accept;
    logic [BBOX_VECTOR_SIZE-1:0] w_pack;

    assign w_full   = (r_cnt >= CNT_W'(DEPTH));
    assign w_accept = (r_state == LOAD) && in_valid && !w_full;
    assign w_pack   = {in_x, in_y, in_width, in_height,
                       in_color1, in_color2, in_d_history};

    assign in_ready   = (r_state == LOAD) && !w_full;
    assign frame_done = (r_state == DONE);
    assign busy       = (r_state != LOAD);
    assign obj_count  = r_cnt;
    assign bbox       = r_bbox;
    assign fe_enable  = r_fe_enable;

    // Object buffer write; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_cnt[AW-1:0]] <= w_pack;
        end
    end

    // Frame sequencer: load objects, replay them with stall, then flag done.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            r_state     <= LOAD;
            r_cnt       <= '0;
            r_rd        <= '0;
            r_bbox      <= '0;
            r_fe_enable <= 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    r_fe_enable <= 1'b0;
                    if (w_accept) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    if (frame_end) begin
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (r_rd == r_cnt) begin
                        r_fe_enable <= 1'b0;
                        r_state     <= DONE;
                    end else if (!fe_stall) begin
                        r_bbox      <= r_mem[r_rd[AW-1:0]];
                        r_fe_enable <= 1'b1;
                        r_rd        <= r_rd + CNT_W'(1);
                    end else begin
                        r_fe_enable <= 1'b0;
                    end
                end
                DONE: begin
                    r_fe_enable <= 1'b0;
                    r_cnt       <= '0;
                    r_rd        <= '0;
                    r_state     <= LOAD;
                end
                default: begin
                    r_fe_enable <= 1'b0;
                    r_state     <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oflow_bbox_feeder.sv
// Self-checking bench for oflow_bbox_feeder: table vectors, directed corner
// sequences and randomized frames against a queue-based frame model.
`timescale 1ns/1ps
module tb_oflow_bbox_feeder;

    localparam int unsigned BV    = 93;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CNT_W = 5;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [9:0]  w;
        logic [9:0]  h;
        logic [23:0] c1;
        logic [23:0] c2;
        logic [2:0]  dh;
    } obj_t;

    typedef struct {
        obj_t          o;
        logic [BV-1:0] exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset_N;
    logic             in_valid;
    logic             in_ready;
    logic [10:0]      in_x, in_y;
    logic [9:0]       in_width, in_height;
    logic [23:0]      in_color1, in_color2;
    logic [2:0]       in_d_history;
    logic             frame_end;
    logic             fe_stall;
    logic [BV-1:0]    bbox;
    logic             fe_enable;
    logic             frame_done;
    logic [CNT_W-1:0] obj_count;
    logic             busy;

    int n_chk  = 0;
    int n_fail = 0;

    oflow_bbox_feeder dut (
        .clk          (clk),
        .reset_N      (reset_N),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_x         (in_x),
        .in_y         (in_y),
        .in_width     (in_width),
        .in_height    (in_height),
        .in_color1    (in_color1),
        .in_color2    (in_color2),
        .in_d_history (in_d_history),
        .frame_end    (frame_end),
        .fe_stall     (fe_stall),
        .bbox         (bbox),
        .fe_enable    (fe_enable),
        .frame_done   (frame_done),
        .obj_count    (obj_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [BV-1:0] pack(input obj_t o);
        return {o.x, o.y, o.w, o.h, o.c1, o.c2, o.dh};
    endfunction

    function automatic obj_t rnd_obj();
        obj_t o;
        o.x  = 11'($urandom);
        o.y  = 11'($urandom);
        o.w  = 10'($urandom);
        o.h  = 10'($urandom);
        o.c1 = 24'($urandom);
        o.c2 = 24'($urandom);
        o.dh = 3'($urandom);
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input obj_t o);
        in_x         = o.x;
        in_y         = o.y;
        in_width     = o.w;
        in_height    = o.h;
        in_color1    = o.c1;
        in_color2    = o.c2;
        in_d_history = o.dh;
    endtask

    // Write a frame's objects back-to-back then close it; ends in the first SEND cycle.
    task automatic load_frame(input obj_t objs[$], input bit fe_with_last);
        for (int i = 0; i < objs.size(); i++) begin
            chk("load_ready", 128'(in_ready), 128'(1'b1));
            chk("load_count", 128'(obj_count), 128'(i));
            drive(objs[i]);
            in_valid  = 1'b1;
            frame_end = (fe_with_last && i == objs.size() - 1);
            step();
        end
        in_valid = 1'b0;
        if (!fe_with_last || objs.size() == 0) begin
            frame_end = 1'b1;
            step();
        end
        frame_end = 1'b0;
    endtask

    // Model the replay: one bbox per unstalled SEND cycle, then one done cycle.
    task automatic replay(input logic [BV-1:0] q[$], input logic [31:0] mask, input bit rnd);
        int idx = 0;
        int it  = 0;
        bit s;
        bit done = 1'b0;
        chk("send_busy", 128'(busy), 128'(1'b1));
        chk("send_fe_first", 128'(fe_enable), 128'(1'b0));
        chk("send_ready", 128'(in_ready), 128'(1'b0));
        while (!done && it < 400) begin
            if (rnd) s = ($urandom_range(0, 2) == 0);
            else     s = (it < 32) ? mask[it] : 1'b0;
            fe_stall = s;
            step();
            if (idx == q.size()) begin
                chk("done_pulse", 128'(frame_done), 128'(1'b1));
                chk("done_count", 128'(obj_count), 128'(q.size()));
                chk("done_fe", 128'(fe_enable), 128'(1'b0));
                done = 1'b1;
            end else begin
                chk("send_no_done", 128'(frame_done), 128'(1'b0));
                if (!s) begin
                    chk("send_fe", 128'(fe_enable), 128'(1'b1));
                    chk("send_bbox", 128'(bbox), 128'(q[idx]));
                    idx++;
                end else begin
                    chk("stall_fe", 128'(fe_enable), 128'(1'b0));
                end
            end
            it++;
        end
        fe_stall = 1'b0;
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL replay_timeout: got %0d of %0d bboxes, no frame_done", idx, q.size());
        end
        step();
        chk("resume_ready", 128'(in_ready), 128'(1'b1));
        chk("resume_busy", 128'(busy), 128'(1'b0));
        chk("resume_done", 128'(frame_done), 128'(1'b0));
        chk("resume_count", 128'(obj_count), 128'(0));
    endtask

    initial begin
        vec_t          tbl[5];
        obj_t          objs[$];
        logic [BV-1:0] q[$];
        logic [BV-1:0] empty_q[$];
        obj_t          o;
        int            m;
        int            len;

        tbl[0].o   = '{11'd50, 11'd10, 10'd10, 10'd100, 24'd50, 24'd60, 3'd6};
        tbl[0].exp = pack(tbl[0].o);
        tbl[1].o   = '{11'd30, 11'd70, 10'd10, 10'd100, 24'd50, 24'd60, 3'd6};
        tbl[1].exp = pack(tbl[1].o);
        tbl[2].o   = '{11'h7FF, 11'h7FF, 10'h3FF, 10'h3FF, 24'hFFFFFF, 24'hFFFFFF, 3'h7};
        tbl[2].exp = '1;
        tbl[3].o   = '{11'h7FF, 11'd0, 10'd0, 10'd0, 24'd0, 24'd0, 3'd0};
        tbl[3].exp = {11'h7FF, 82'd0};
        tbl[4].o   = '{11'd0, 11'd0, 10'd0, 10'd0, 24'd0, 24'd0, 3'd5};
        tbl[4].exp = 93'd5;

        reset_N   = 1'b0;
        in_valid  = 1'b0;
        frame_end = 1'b0;
        fe_stall  = 1'b0;
        drive('0);
        #12;
        chk("rst_ready", 128'(in_ready), 128'(1'b1));
        chk("rst_bbox", 128'(bbox), 128'(0));
        chk("rst_fe", 128'(fe_enable), 128'(1'b0));
        chk("rst_done", 128'(frame_done), 128'(1'b0));
        chk("rst_count", 128'(obj_count), 128'(0));
        chk("rst_busy", 128'(busy), 128'(1'b0));
        @(negedge clk);
        reset_N = 1'b1;

        // Two-object frame from the table
        objs = {};
        q    = {};
        for (int i = 0; i < 2; i++) begin
            objs.push_back(tbl[i].o);
            q.push_back(tbl[i].exp);
        end
        load_frame(objs, 1'b0);
        replay(q, 32'h0, 1'b0);

        // Remaining table vectors as one frame
        objs = {};
        q    = {};
        for (int i = 2; i < 5; i++) begin
            objs.push_back(tbl[i].o);
            q.push_back(tbl[i].exp);
        end
        load_frame(objs, 1'b0);
        replay(q, 32'h0, 1'b0);

        // Seventeen objects: backpressure after the sixteenth
        objs = {};
        q    = {};
        for (int i = 0; i < 17; i++) objs.push_back(rnd_obj());
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(objs[i]);
            chk("fill_ready", 128'(in_ready), 128'(1'b1));
            step();
            q.push_back(pack(objs[i]));
        end
        drive(objs[16]);
        chk("full_ready", 128'(in_ready), 128'(1'b0));
        chk("full_count", 128'(obj_count), 128'(16));
        step();
        chk("full_hold", 128'(in_ready), 128'(1'b0));
        chk("full_hold_count", 128'(obj_count), 128'(16));
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        replay(q, 32'h0, 1'b0);
        step();
        in_valid = 1'b0;
        chk("late_accept", 128'(obj_count), 128'(1));
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        q = {};
        q.push_back(pack(objs[16]));
        replay(q, 32'h0, 1'b0);

        // Empty frame
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        replay(empty_q, 32'h0, 1'b0);

        // Stall on the cycle that would issue object 1
        objs = {};
        q    = {};
        for (int i = 0; i < 3; i++) begin
            o = rnd_obj();
            objs.push_back(o);
            q.push_back(pack(o));
        end
        load_frame(objs, 1'b0);
        replay(q, 32'h2, 1'b0);

        // frame_end coincident with the third accepted object
        objs = {};
        q    = {};
        for (int i = 0; i < 3; i++) begin
            o = rnd_obj();
            objs.push_back(o);
            q.push_back(pack(o));
        end
        load_frame(objs, 1'b1);
        replay(q, 32'h0, 1'b0);

        // Reset in the middle of a replay
        objs = {};
        for (int i = 0; i < 3; i++) objs.push_back(rnd_obj());
        load_frame(objs, 1'b0);
        step();
        chk("pre_rst_fe", 128'(fe_enable), 128'(1'b1));
        reset_N = 1'b0;
        #1;
        chk("midrst_fe", 128'(fe_enable), 128'(1'b0));
        chk("midrst_busy", 128'(busy), 128'(1'b0));
        chk("midrst_ready", 128'(in_ready), 128'(1'b1));
        chk("midrst_count", 128'(obj_count), 128'(0));
        @(negedge clk);
        reset_N = 1'b1;
        objs = {};
        q    = {};
        o = rnd_obj();
        objs.push_back(o);
        q.push_back(pack(o));
        load_frame(objs, 1'b0);
        replay(q, 32'h0, 1'b0);

        // Randomized frames with gaps, overflow attempts and random stalls
        for (int f = 0; f < 10; f++) begin
            q   = {};
            m   = 0;
            len = $urandom_range(1, 25);
            for (int c = 0; c < len; c++) begin
                o = rnd_obj();
                drive(o);
                in_valid  = ($urandom_range(0, 3) != 0);
                frame_end = (c == len - 1);
                chk("rnd_ready", 128'(in_ready), 128'(m < DEPTH));
                chk("rnd_count", 128'(obj_count), 128'(m));
                if (in_valid && m < DEPTH) begin
                    q.push_back(pack(o));
                    m++;
                end
                step();
            end
            in_valid  = 1'b0;
            frame_end = 1'b0;
            replay(q, 32'h0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
